// File: rtl/cpld_spi_master.sv
// SPI mode-0, LSB-first master: one opcode byte then `length` payload bytes per nSS-low frame.
// Optional abort support when CPLD_SPI_MASTER_ABORT_EN is defined (adds `abort` / `aborted`).
module cpld_spi_master #(
    parameter int CLK_DIV   = 4,
    parameter int LEN_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
`ifdef CPLD_SPI_MASTER_ABORT_EN
    input  logic                 abort,
    output logic                 aborted,
`endif
    input  logic                 start,
    input  logic [7:0]           opcode,
    input  logic [LEN_WIDTH-1:0] length,
    input  logic [7:0]           tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [7:0]           rx_data,
    output logic                 rx_valid,
    output logic                 busy,
    output logic                 done,
    output logic                 spi_nss,
    output logic                 spi_sck,
    output logic                 spi_mosi,
    input  logic                 spi_miso
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE, SETUP, SHIFT_HI, SHIFT_LO, LOAD, TAIL, DONE
    } state_t;

    state_t               state;
    logic [CW-1:0]        div_cnt;
    logic [2:0]           bit_cnt;
    logic [LEN_WIDTH-1:0] byte_cnt;
    logic [LEN_WIDTH-1:0] len_q;
    logic [7:0]           tx_sr;
    logic [7:0]           rx_sr;
    logic                 div_last;
    logic                 stop_early;

    assign div_last = (div_cnt == DIV_LAST);

`ifdef CPLD_SPI_MASTER_ABORT_EN
    logic abort_pend;
    // A request arriving on the very boundary cycle still takes effect there.
    assign stop_early = abort_pend | abort;
`else
    assign stop_early = 1'b0;
`endif

    // NOTE: every register below uses non-blocking assignment so all branches see pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            len_q    <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            tx_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            spi_nss  <= 1'b1;
            spi_sck  <= 1'b0;
            spi_mosi <= 1'b0;
`ifdef CPLD_SPI_MASTER_ABORT_EN
            abort_pend <= 1'b0;
            aborted    <= 1'b0;
`endif
        end else begin
            done     <= 1'b0;
            rx_valid <= 1'b0;
`ifdef CPLD_SPI_MASTER_ABORT_EN
            aborted <= 1'b0;
            if (abort && busy && state != TAIL)
                abort_pend <= 1'b1;
`endif
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q    <= length;
                        tx_sr    <= opcode;
                        spi_mosi <= opcode[0];
                        spi_nss  <= 1'b0;
                        busy     <= 1'b1;
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                        byte_cnt <= '0;
                        state    <= SETUP;
                    end
                end
                SETUP, SHIFT_LO: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        spi_sck <= 1'b1;
                        rx_sr   <= {spi_miso, rx_sr[7:1]};
                        state   <= SHIFT_HI;
                    end else begin
                        div_cnt <= div_cnt + CW'(1);
                    end
                end
                SHIFT_HI: begin
                    // Opcode byte (byte_cnt == 0) is shifted in but never reported.
                    if (div_cnt == '0 && bit_cnt == 3'd7 && byte_cnt != '0) begin
                        rx_valid <= 1'b1;
                        rx_data  <= rx_sr;
                    end
                    if (div_last) begin
                        div_cnt <= '0;
                        spi_sck <= 1'b0;
                        if (bit_cnt != 3'd7) begin
                            bit_cnt  <= bit_cnt + 3'd1;
                            tx_sr    <= tx_sr >> 1;
                            spi_mosi <= tx_sr[1];
                            state    <= SHIFT_LO;
                        end else if (byte_cnt != len_q && !stop_early) begin
                            tx_ready <= 1'b1;
                            state    <= LOAD;
                        end else begin
                            state <= TAIL;
                        end
                    end else begin
                        div_cnt <= div_cnt + CW'(1);
                    end
                end
                LOAD: begin
                    // tx_ready stays high every stalled cycle; SCK is frozen low meanwhile.
                    if (tx_valid) begin
                        tx_ready <= 1'b0;
                        tx_sr    <= tx_data;
                        spi_mosi <= tx_data[0];
                        bit_cnt  <= '0;
                        byte_cnt <= byte_cnt + LEN_WIDTH'(1);
                        div_cnt  <= '0;
                        state    <= SHIFT_LO;
                    end else begin
                        tx_ready <= 1'b1;
                    end
                end
                TAIL: begin
                    if (div_last) begin
                        div_cnt  <= '0;
                        spi_nss  <= 1'b1;
                        spi_mosi <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
`ifdef CPLD_SPI_MASTER_ABORT_EN
                        aborted  <= abort_pend;
`endif
                        state    <= DONE;
                    end else begin
                        div_cnt <= div_cnt + CW'(1);
                    end
                end
                DONE: begin
                    bit_cnt  <= '0;
                    byte_cnt <= '0;
`ifdef CPLD_SPI_MASTER_ABORT_EN
                    abort_pend <= 1'b0;
`endif
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
